// File: rtl/fetch_stage.sv
// Two-phase instruction fetch stage: FETCH latches the ROM byte and advances pc,
// EXEC presents the instruction and optionally takes a jump, HALT freezes the stage.
module fetch_stage #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        prog_byte,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        instr,
    output logic [3:0]        oprnd,
    output logic              oprnd_oe,
    output logic              valid,
    output logic              halted
);

    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [3:0]        instr_nxt;
    logic [3:0]        oprnd_nxt;

    // Next-state and datapath update; everything holds unless enabled.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
        oprnd_nxt = oprnd;
        if (enable) begin
            unique case (state)
                FETCH: begin
                    instr_nxt = prog_byte[7:4];
                    oprnd_nxt = prog_byte[3:0];
                    pc_nxt    = pc + ADDR_W'(1);
                    state_nxt = (prog_byte[7:4] == OP_HLT) ? HALT : EXEC;
                end
                EXEC: begin
                    if (pc_load) begin
                        pc_nxt = load_addr;
                    end
                    state_nxt = FETCH;
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= '0;
            instr    <= '0;
            oprnd    <= '0;
            valid    <= 1'b0;
            oprnd_oe <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            instr    <= instr_nxt;
            oprnd    <= oprnd_nxt;
            valid    <= (state_nxt == EXEC);
            oprnd_oe <= (state_nxt == EXEC);
            halted   <= (state_nxt == HALT);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all compared
// cycle by cycle against a behavioural model of the fetch/execute/halt rules.
module tb_fetch_stage;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned PC_MOD = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [7:0]        prog_byte = 8'h00;
    logic              pc_load = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        instr;
    logic [3:0]        oprnd;
    logic              oprnd_oe;
    logic              valid;
    logic              halted;

    int checks = 0;
    int errors = 0;

    // Reference model: pc as an integer, plus "executing" and "stopped" flags.
    int unsigned m_pc = 0;
    int unsigned m_instr = 0;
    int unsigned m_oprnd = 0;
    bit          m_exec = 1'b0;
    bit          m_stop = 1'b0;

    fetch_stage #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .prog_byte (prog_byte),
        .pc_load   (pc_load),
        .load_addr (load_addr),
        .pc        (pc),
        .instr     (instr),
        .oprnd     (oprnd),
        .oprnd_oe  (oprnd_oe),
        .valid     (valid),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input int unsigned pb,
                              input bit pl, input int unsigned la);
        if (r) begin
            m_pc = 0; m_instr = 0; m_oprnd = 0; m_exec = 0; m_stop = 0;
        end else if (e && !m_stop) begin
            if (m_exec) begin
                if (pl) m_pc = la;
                m_exec = 0;
            end else begin
                m_instr = pb / 16;
                m_oprnd = pb % 16;
                m_pc    = (m_pc + 1) % PC_MOD;
                if (m_instr == 15) m_stop = 1; else m_exec = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},       32'(pc),       32'(m_pc));
        chk({tag, ".instr"},    32'(instr),    32'(m_instr));
        chk({tag, ".oprnd"},    32'(oprnd),    32'(m_oprnd));
        chk({tag, ".valid"},    32'(valid),    32'(m_exec));
        chk({tag, ".oprnd_oe"}, 32'(oprnd_oe), 32'(m_exec));
        chk({tag, ".halted"},   32'(halted),   32'(m_stop));
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic [7:0] pb,
                        input logic pl, input logic [ADDR_W-1:0] la);
        reset = r; enable = e; prog_byte = pb; pc_load = pl; load_addr = la;
        @(posedge clk);
        model_edge(r, e, 32'(pb), pl, 32'(la));
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset state
        step("reset", 1, 0, 8'h00, 0, '0);
        chk("reset.pc0", 32'(pc), 32'h0);

        // Basic fetch then exec
        step("fetch35", 0, 1, 8'h35, 0, '0);
        chk("fetch35.instr", 32'(instr), 32'h3);
        chk("fetch35.oprnd", 32'(oprnd), 32'h5);
        chk("fetch35.oe",    32'(oprnd_oe), 32'h1);
        chk("fetch35.pc",    32'(pc), 32'h1);
        step("exec35", 0, 1, 8'h99, 0, '0);
        chk("exec35.valid", 32'(valid), 32'h0);
        chk("exec35.pc",    32'(pc), 32'h1);

        // Jump honoured in EXEC, ignored in FETCH
        step("fetch20", 0, 1, 8'h20, 0, '0);
        step("jmp0a0", 0, 1, 8'h00, 1, 12'h0A0);
        chk("jmp0a0.pc", 32'(pc), 32'h0A0);
        step("fetchjmp", 0, 1, 8'h45, 1, 12'h555);
        chk("fetchjmp.pc", 32'(pc), 32'h0A1);

        // Stall in EXEC
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 0, 8'hC3, 1, 12'h777);
            chk("stall.oprnd", 32'(oprnd), 32'h5);
            chk("stall.oe",    32'(oprnd_oe), 32'h1);
            chk("stall.pc",    32'(pc), 32'h0A1);
        end

        // pc wrap from all-ones
        step("jmpfff", 0, 1, 8'h00, 1, 12'hFFF);
        chk("jmpfff.pc", 32'(pc), 32'hFFF);
        step("wrap12", 0, 1, 8'h12, 0, '0);
        chk("wrap12.pc",    32'(pc), 32'h000);
        chk("wrap12.instr", 32'(instr), 32'h1);
        chk("wrap12.oprnd", 32'(oprnd), 32'h2);
        step("wrapexec", 0, 1, 8'h00, 0, '0);

        // Halt is absorbing until reset
        step("hlt", 0, 1, 8'hF7, 0, '0);
        chk("hlt.halted", 32'(halted), 32'h1);
        chk("hlt.oe",     32'(oprnd_oe), 32'h0);
        chk("hlt.pc",     32'(pc), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step("frozen", 0, 1, 8'(i * 37), 1, 12'h3C3);
            chk("frozen.pc", 32'(pc), 32'h1);
        end
        step("hltreset", 1, 1, 8'h00, 1, 12'h3C3);
        chk("hltreset.halted", 32'(halted), 32'h0);
        chk("hltreset.pc",     32'(pc), 32'h0);

        // Reset in EXEC discards the pending jump
        step("pre37", 0, 1, 8'h35, 0, '0);
        step("rst37", 1, 1, 8'h00, 1, 12'h123);
        chk("rst37.pc",    32'(pc), 32'h0);
        chk("rst37.valid", 32'(valid), 32'h0);
        step("post37", 0, 1, 8'h61, 0, '0);
        chk("post37.pc",    32'(pc), 32'h1);
        chk("post37.instr", 32'(instr), 32'h6);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic r, e, pl;
            logic [7:0] pb;
            r  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 4) != 0);
            pl = $urandom_range(0, 1) == 1;
            pb = 8'($urandom);
            step("rand", r, e, pb, pl, ADDR_W'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 12: program-counter and ROM-address width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 enable  input  1  stage advance; when 0, all state SHALL hold.
REQ-005 prog_byte  input  8  ROM data at address pc; [7:4] opcode, [3:0] operand.
REQ-006 pc_load  input  1  jump request; honoured only in EXEC.
REQ-007 load_addr  input  ADDR_W  jump target.
REQ-008 pc  output  ADDR_W  ROM address, registered.
REQ-009 instr  output  4  latched opcode, registered.
REQ-010 oprnd  output  4  latched operand, registered; data input of the downstream 4-bit tri-state bus buffer.
REQ-011 oprnd_oe  output  1  output enable for the downstream bus buffer.
REQ-012 valid  output  1  instr/oprnd hold a fetched instruction being executed.
REQ-013 halted  output  1  HLT opcode reached.

Function
REQ-014 The block SHALL implement a three-state FSM: FETCH, EXEC, HALT.
REQ-015 FETCH with enable=1: instr<=prog_byte[7:4], oprnd<=prog_byte[3:0], pc<=pc+1, next state EXEC.
REQ-016 FETCH with enable=1 and prog_byte[7:4]=4'hF: instr/oprnd latched, pc<=pc+1, next state HALT.
REQ-017 EXEC with enable=1, pc_load=0: pc holds, next state FETCH.
REQ-018 EXEC with enable=1, pc_load=1: pc<=load_addr, next state FETCH.
REQ-019 pc_load SHALL be ignored in FETCH and HALT.
REQ-020 enable=0 in any state: pc, instr, oprnd and state SHALL hold; outputs unchanged.
REQ-021 HALT SHALL be absorbing: no state, pc, instr or oprnd change until reset, regardless of enable or pc_load.
REQ-022 pc increment SHALL wrap modulo 2^ADDR_W (all-ones + 1 -> 0) without flag or stall.
REQ-023 valid SHALL be 1 exactly when state is EXEC; decoded from the state register, no combinational input path.
REQ-024 oprnd_oe SHALL be 1 exactly when state is EXEC; 0 in FETCH and HALT, so the bus buffer drives high-Z outside execution.
REQ-025 halted SHALL be 1 exactly when state is HALT.
REQ-026 Latency: prog_byte sampled in FETCH SHALL appear on instr/oprnd one cycle later, with valid and oprnd_oe asserted in the same cycle.
REQ-027 Throughput: one instruction per two enabled cycles.

Reset
REQ-028 reset=1 at a rising edge SHALL force state FETCH, pc=0, instr=0, oprnd=0, valid=0, oprnd_oe=0, halted=0.
REQ-029 reset SHALL take priority over enable, pc_load and every state including HALT.
REQ-030 reset asserted mid-instruction (in EXEC) SHALL discard the instruction; no pc_load is applied that cycle.
REQ-031 After reset deasserts, the first enabled edge SHALL perform FETCH from address 0.

Verification
REQ-032 Reset, enable=1, prog_byte=8'h35 at pc=0 -> next cycle instr=3, oprnd=5, valid=1, oprnd_oe=1, pc=1; following cycle valid=0, oprnd_oe=0, pc=1.
REQ-033 EXEC with pc_load=1, load_addr=12'h0A0 -> after edge pc=12'h0A0, state FETCH; same request in FETCH -> pc unaffected.
REQ-034 enable=0 held 3 cycles in EXEC with oprnd=5 -> pc, instr, oprnd, oprnd_oe=1 unchanged throughout.
REQ-035 pc forced to 12'hFFF via pc_load, FETCH of 8'h12 -> pc=12'h000, instr=1, oprnd=2.
REQ-036 prog_byte=8'hF7 in FETCH -> halted=1, oprnd_oe=0, pc=+1, then frozen for 5 cycles with enable=1 and pc_load=1; reset -> halted=0, pc=0.
REQ-037 reset asserted in EXEC with pc_load=1, load_addr=12'h123 -> pc=0, valid=0, state FETCH; 12'h123 never appears on pc.
